// File: rtl/timer_6801_multi.sv
// Programmable timer: free-running 16-bit counter with prescaler, OC_CH output
// compares, IC_CH input captures and a clear-on-compare period mode.
module timer_6801_multi #(
  parameter int OC_CH = 2,
  parameter int IC_CH = 1,
  parameter int PRE_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             cs,
  input  logic             rw,
  input  logic [4:0]       addr,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  input  logic [IC_CH-1:0] ic_in,
  output logic [OC_CH-1:0] oc_out,
  output logic             irq_tof,
  output logic             irq_ocf,
  output logic             irq_icf
);

  localparam int NF = 1 + OC_CH + IC_CH;  // flag bits in STAT/IEN
  localparam int CW = 4 + IC_CH;          // implemented CTRL bits

  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_cnt;
  logic [7:0]       r_cnt_wbuf;
  logic [7:0]       r_cnt_rbuf;
  logic             r_cnt_rvld;
  logic [15:0]      r_ocr      [OC_CH];
  logic [7:0]       r_ocr_wbuf [OC_CH];
  logic [15:0]      r_icr      [IC_CH];
  logic [7:0]       r_icr_rbuf [IC_CH];
  logic [IC_CH-1:0] r_icr_rvld;
  logic [NF-1:0]    r_stat;
  logic [NF-1:0]    r_ien;
  logic [CW-1:0]    r_ctrl;
  logic [OC_CH-1:0] r_olvl;
  logic [OC_CH-1:0] r_oc;
  logic [IC_CH-1:0] r_ic_s1, r_ic_s2, r_ic_h;

  logic             w_wr, w_rd, w_tick, w_step, w_cnt_commit, w_clr_hit, w_ctrl_wr;
  logic [15:0]      w_cnt_upd;
  logic [OC_CH-1:0] w_oc_hit;
  logic [IC_CH-1:0] w_ic_edge;
  logic [NF-1:0]    w_set, w_clr;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    w_wr         = cs & ~hold & ~rw;
    w_rd         = cs & ~hold & rw;
    w_ctrl_wr    = w_wr && (addr == 5'h02);
    w_cnt_commit = w_wr && (addr == 5'h05);
    w_tick       = 1'b1;
    unique case (r_ctrl[1:0])
      2'd0: w_tick = 1'b1;
      2'd1: w_tick = r_pre[0];
      2'd2: w_tick = &r_pre[1:0];
      2'd3: w_tick = &r_pre[2:0];
    endcase
    // A CNT commit wins over the tick, so that edge neither counts nor compares.
    w_step    = w_tick & r_ctrl[2] & ~w_cnt_commit;
    w_clr_hit = r_ctrl[3] && (r_cnt == r_ocr[0]);
    w_cnt_upd = w_clr_hit ? 16'h0000 : r_cnt + 16'd1;
    w_set     = '0;
    w_set[0]  = w_step && !w_clr_hit && (r_cnt == 16'hFFFF);
    for (int i = 0; i < OC_CH; i++) begin
      if (i == 0 && r_ctrl[3]) w_oc_hit[i] = w_step & w_clr_hit;
      else                     w_oc_hit[i] = w_step && (w_cnt_upd == r_ocr[i]);
      w_set[1+i] = w_oc_hit[i];
    end
    for (int j = 0; j < IC_CH; j++) begin
      w_ic_edge[j] = r_ctrl[4+j] ? (r_ic_s2[j] & ~r_ic_h[j]) : (~r_ic_s2[j] & r_ic_h[j]);
      w_set[1+OC_CH+j] = w_ic_edge[j];
    end
    w_clr = (w_wr && addr == 5'h00) ? data_in[NF-1:0] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only; the small
  // OCR/ICR arrays are reset explicitly because their reset values are visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre      <= '0;
      r_cnt      <= 16'h0000;
      r_cnt_wbuf <= '0;
      r_cnt_rbuf <= '0;
      r_cnt_rvld <= 1'b0;
      r_stat     <= '0;
      r_ien      <= '0;
      r_ctrl     <= CW'(8'h04);
      r_olvl     <= '0;
      r_oc       <= '0;
      r_ic_s1    <= '0;
      r_ic_s2    <= '0;
      r_ic_h     <= '0;
      r_icr_rvld <= '0;
      for (int i = 0; i < OC_CH; i++) begin
        r_ocr[i]      <= 16'hFFFF;
        r_ocr_wbuf[i] <= '0;
      end
      for (int j = 0; j < IC_CH; j++) begin
        r_icr[j]      <= 16'h0000;
        r_icr_rbuf[j] <= '0;
      end
    end else begin
      r_pre  <= w_ctrl_wr ? '0 : r_pre + PRE_W'(1);
      r_stat <= (r_stat & ~w_clr) | w_set;

      if (w_wr) begin
        unique case (addr)
          5'h01:   r_ien      <= data_in[NF-1:0];
          5'h02:   r_ctrl     <= data_in[CW-1:0];
          5'h03:   r_olvl     <= data_in[OC_CH-1:0];
          5'h04:   r_cnt_wbuf <= data_in;
          default: ;
        endcase
      end

      if (w_cnt_commit) r_cnt <= {r_cnt_wbuf, data_in};
      else if (w_step)  r_cnt <= w_cnt_upd;

      for (int i = 0; i < OC_CH; i++) begin
        if (w_wr && addr == 5'(8 + 2*i)) r_ocr_wbuf[i] <= data_in;
        if (w_wr && addr == 5'(9 + 2*i)) r_ocr[i] <= {r_ocr_wbuf[i], data_in};
        if (w_oc_hit[i]) r_oc[i] <= r_olvl[i];
      end

      // High-byte read freezes the low byte until the matching low-byte read.
      if (w_rd && addr == 5'h04) begin
        r_cnt_rbuf <= r_cnt[7:0];
        r_cnt_rvld <= 1'b1;
      end
      if (w_rd && addr == 5'h05) r_cnt_rvld <= 1'b0;

      r_ic_s1 <= ic_in;
      r_ic_s2 <= r_ic_s1;
      r_ic_h  <= r_ic_s2;
      for (int j = 0; j < IC_CH; j++) begin
        if (w_ic_edge[j]) r_icr[j] <= r_cnt;
        if (w_rd && addr == 5'(16 + 2*j)) begin
          r_icr_rbuf[j] <= r_icr[j][7:0];
          r_icr_rvld[j] <= 1'b1;
        end
        if (w_rd && addr == 5'(17 + 2*j)) r_icr_rvld[j] <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    unique case (addr)
      5'h00:   data_out = 8'(r_stat);
      5'h01:   data_out = 8'(r_ien);
      5'h02:   data_out = 8'(r_ctrl);
      5'h03:   data_out = 8'(r_olvl);
      5'h04:   data_out = r_cnt[15:8];
      5'h05:   data_out = r_cnt_rvld ? r_cnt_rbuf : r_cnt[7:0];
      default: ;
    endcase
    for (int i = 0; i < OC_CH; i++) begin
      if (addr == 5'(8 + 2*i)) data_out = r_ocr[i][15:8];
      if (addr == 5'(9 + 2*i)) data_out = r_ocr[i][7:0];
    end
    for (int j = 0; j < IC_CH; j++) begin
      if (addr == 5'(16 + 2*j)) data_out = r_icr[j][15:8];
      if (addr == 5'(17 + 2*j)) data_out = r_icr_rvld[j] ? r_icr_rbuf[j] : r_icr[j][7:0];
    end
  end

  assign oc_out  = r_oc;
  assign irq_tof = r_stat[0] & r_ien[0];
  assign irq_ocf = |(r_stat[OC_CH:1] & r_ien[OC_CH:1]);
  assign irq_icf = |(r_stat[NF-1:OC_CH+1] & r_ien[NF-1:OC_CH+1]);

endmodule
